wb_write_queue: RTL

//  Write-back queue directly upstream of the 32x64 register file.
//  - Accepts results from the execute/memory stages over a valid/ready handshake.
//  - Buffers them in order and drives the register file's single write port, at most one write per cycle.
//  - Optional forwarding lets readers see values still queued and not yet committed.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 64 ++++++
 rtl/wb_write_queue.sv | 112 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back queue feeding the 32x64 register file.
// Optional forwarding is enabled by defining WB_QUEUE_BYPASS_EN.
package wb_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_entry_t;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/wb_fifo.sv
// In-order entry storage with wrapping pointers and occupancy count.
// Exposes raw storage only when WB_QUEUE_BYPASS_EN is defined.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  wb_entry_t     din,
  output wb_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
`ifdef WB_QUEUE_BYPASS_EN
  ,
  output wb_entry_t     mem_o [DEPTH],
  output logic [PW-1:0] rd_ptr_o
`endif
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

`ifdef WB_QUEUE_BYPASS_EN
  assign mem_o    = mem_q;
  assign rd_ptr_o = rd_ptr_q;
`endif

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue: XZR filter, drain gating and optional forwarding.
// Forwarding search is built only with WB_QUEUE_BYPASS_EN defined.
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_reg,
  input  logic [DW-1:0] in_data,
  input  logic          hold,
  output logic          RegWrite,
  output logic [4:0]    WriteRegister,
  output logic [DW-1:0] WriteData,
  output logic [CW-1:0] count,
  input  logic [4:0]    ReadRegister1,
  input  logic [4:0]    ReadRegister2,
  output logic          fwd_hit1,
  output logic [DW-1:0] fwd_data1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data2
);

  wb_entry_t     din;
  wb_entry_t     head;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          push;

  // X31 writes are consumed here and never occupy a slot
  assign in_ready = ~full;
  assign push     = in_valid & in_ready & (in_reg != XZR);
  assign din.rd   = in_reg;
  assign din.data = in_data;

  assign RegWrite      = ~empty & ~hold;
  assign WriteRegister = RegWrite ? head.rd : '0;
  assign WriteData     = RegWrite ? head.data : '0;
  assign count         = cnt;

`ifdef WB_QUEUE_BYPASS_EN
  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] idx;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (RegWrite),
    .din      (din),
    .head     (head),
    .count    (cnt),
    .full     (full),
    .empty    (empty),
    .mem_o    (mem),
    .rd_ptr_o (rd_ptr)
  );

  // oldest to youngest, so the last match is the youngest
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < cnt) begin
        if (mem[idx].rd == ReadRegister1 &&
            ReadRegister1 != XZR) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = mem[idx].data;
        end
        if (mem[idx].rd == ReadRegister2 &&
            ReadRegister2 != XZR) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = mem[idx].data;
        end
      end
    end
  end
`else
  logic unused_rd;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (RegWrite),
    .din   (din),
    .head  (head),
    .count (cnt),
    .full  (full),
    .empty (empty)
  );

  assign unused_rd = ^{ReadRegister1, ReadRegister2};
  assign fwd_hit1  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data2 = '0;
`endif

endmodule
